// File: rtl/cascade_pkg.sv
// rtl/cascade_pkg.sv - shared types and constants for the cascade-bus sequencer
//
// Contents:
//   CAS_W_DEFAULT  default cascade ID width
//   CALL_OPCODE    MCS-80 CALL opcode placed on the bus by the master in ACK1
//   state_e        sequencer states
//   BSEL_*         byte_sel codes for the current INTA byte
package cascade_pkg;

  localparam int CAS_W_DEFAULT = 3;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACK1 = 3'd1,
    ST_GAP1 = 3'd2,
    ST_ACK2 = 3'd3,
    ST_GAP2 = 3'd4,
    ST_ACK3 = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  localparam logic [1:0] BSEL_CALL = 2'd0;
  localparam logic [1:0] BSEL_VEC1 = 2'd1;
  localparam logic [1:0] BSEL_VEC2 = 2'd2;

endpackage

// File: rtl/inta_edge_detect.sv
// rtl/inta_edge_detect.sv - INTA strobe edge detector
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   inta_n  in   INTA strobe, already synchronised to clk
//   fall    out  inta_n went high->low this cycle
//   rise    out  inta_n went low->high this cycle
//
// The delayed copy resets high (strobe idle), so a strobe already low when
// reset releases is seen as a fall.
module inta_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic inta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_q <= 1'b1;
    end else begin
      inta_q <= inta_n;
    end
  end

  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;

endmodule

// File: rtl/cascade_sequencer.sv
// rtl/cascade_sequencer.sv - PIC cascade-bus sequencer (INTA tracking, CAS drive, vector enables)
//
// Optional feature macro: CASCADE_MCS80_EN (adds the 3-INTA MCS-80 sequence
// selected by upm=0; without it upm is ignored and only the 8086 sequence exists).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sp_n         1 = master, 0 = slave
//   sngl         single (non-cascaded) system
//   upm          1 = 8086 (2 INTA), 0 = MCS-80 (3 INTA, macro builds only)
//   icw3         master: slave-present mask per IR; slave: [CAS_W-1:0] own ID
//   inta_n       synchronised INTA strobe
//   ack_ir       IR being acknowledged
//   cas_i        CAS pins in
//   cas_o/cas_oe CAS pins out / output enable (master only)
//   addressed    this device owns the vector for the current cycle
//   vector_en    drive the data bus for the current INTA byte
//   byte_sel     0 = CALL opcode, 1 = first vector byte, 2 = second vector byte
//   cycle_done   one-clock pulse after the final INTA rise
module cascade_sequencer
  import cascade_pkg::*;
#(
  parameter  int CAS_W  = CAS_W_DEFAULT,
  localparam int NUM_IR = 2 ** CAS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sp_n,
  input  logic              sngl,
  input  logic              upm,
  input  logic [NUM_IR-1:0] icw3,
  input  logic              inta_n,
  input  logic [CAS_W-1:0]  ack_ir,
  input  logic [CAS_W-1:0]  cas_i,
  output logic [CAS_W-1:0]  cas_o,
  output logic              cas_oe,
  output logic              addressed,
  output logic              vector_en,
  output logic [1:0]        byte_sel,
  output logic              cycle_done
);

  logic fall;
  logic rise;

  inta_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .inta_n (inta_n),
    .fall   (fall),
    .rise   (rise)
  );

  state_e             state_q, state_d;
  logic               casc_q, casc_d;
  logic               match_q, match_d;
  logic               master_q, master_d;
  logic [CAS_W-1:0]   id_q, id_d;
`ifdef CASCADE_MCS80_EN
  logic               mcs80_q, mcs80_d;
`else
  logic               unused_upm;
  assign unused_upm = upm;
`endif

  logic               start;
  logic               in_cycle;
  logic               cas_active;
  logic [CAS_W-1:0]   cas_o_d;
  logic               cas_oe_d;
  logic               addressed_d;
  logic               vector_en_d;
  logic [1:0]         byte_sel_d;
  logic               cycle_done_d;

  always_comb begin
    state_d  = state_q;
    casc_d   = casc_q;
    match_d  = match_q;
    master_d = master_q;
    id_d     = id_q;
`ifdef CASCADE_MCS80_EN
    mcs80_d  = mcs80_q;
`endif
    start    = 1'b0;

    case (state_q)
      ST_IDLE: if (fall) start = 1'b1;
      ST_ACK1: if (rise) state_d = ST_GAP1;
      ST_GAP1: if (fall) state_d = ST_ACK2;
`ifdef CASCADE_MCS80_EN
      ST_ACK2: if (rise) state_d = mcs80_q ? ST_GAP2 : ST_DONE;
      ST_GAP2: if (fall) state_d = ST_ACK3;
      ST_ACK3: if (rise) state_d = ST_DONE;
`else
      ST_ACK2: if (rise) state_d = ST_DONE;
`endif
      // A fall right after the last rise begins the next acknowledge.
      ST_DONE: begin
        if (fall) start = 1'b1;
        else      state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Configuration inputs are captured only here; they are ignored for
    // the rest of the cycle.
    if (start) begin
      state_d  = ST_ACK1;
      casc_d   = sp_n & ~sngl & icw3[ack_ir];
      match_d  = ~sp_n & (sngl | (cas_i == icw3[CAS_W-1:0]));
      master_d = sp_n;
      id_d     = ack_ir;
`ifdef CASCADE_MCS80_EN
      mcs80_d  = ~upm;
`endif
    end

    // Outputs are computed from the next state so they register together
    // with it, one clock after the causing edge.
    in_cycle     = (state_d != ST_IDLE);
    cas_active   = in_cycle && (state_d != ST_DONE);
    cas_oe_d     = cas_active & casc_d;
    cas_o_d      = cas_oe_d ? id_d : '0;
    addressed_d  = in_cycle & (master_d ? ~casc_d : match_d);
    vector_en_d  = addressed_d & ((state_d == ST_ACK2) || (state_d == ST_ACK3));
`ifdef CASCADE_MCS80_EN
    // The CALL opcode byte comes from the master alone.
    if ((state_d == ST_ACK1) && mcs80_d && master_d) begin
      vector_en_d = 1'b1;
    end
`endif
    byte_sel_d   = BSEL_CALL;
    if (state_d == ST_ACK2) byte_sel_d = BSEL_VEC1;
    if (state_d == ST_ACK3) byte_sel_d = BSEL_VEC2;
    cycle_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      casc_q     <= 1'b0;
      match_q    <= 1'b0;
      master_q   <= 1'b0;
      id_q       <= '0;
`ifdef CASCADE_MCS80_EN
      mcs80_q    <= 1'b0;
`endif
      cas_o      <= '0;
      cas_oe     <= 1'b0;
      addressed  <= 1'b0;
      vector_en  <= 1'b0;
      byte_sel   <= BSEL_CALL;
      cycle_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      casc_q     <= casc_d;
      match_q    <= match_d;
      master_q   <= master_d;
      id_q       <= id_d;
`ifdef CASCADE_MCS80_EN
      mcs80_q    <= mcs80_d;
`endif
      cas_o      <= cas_o_d;
      cas_oe     <= cas_oe_d;
      addressed  <= addressed_d;
      vector_en  <= vector_en_d;
      byte_sel   <= byte_sel_d;
      cycle_done <= cycle_done_d;
    end
  end

endmodule

// File: tb/tb_cascade_sequencer.sv
// tb/tb_cascade_sequencer.sv - directed self-checking bench for cascade_sequencer
module tb_cascade_sequencer;
  import cascade_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       sp_n;
  logic       sngl;
  logic       upm;
  logic [7:0] icw3;
  logic       inta_n;
  logic [2:0] ack_ir;
  logic [2:0] cas_i;
  logic [2:0] cas_o;
  logic       cas_oe;
  logic       addressed;
  logic       vector_en;
  logic [1:0] byte_sel;
  logic       cycle_done;

  int n_assert = 0;
  int n_fail   = 0;

  cascade_sequencer #(.CAS_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sp_n       (sp_n),
    .sngl       (sngl),
    .upm        (upm),
    .icw3       (icw3),
    .inta_n     (inta_n),
    .ack_ir     (ack_ir),
    .cas_i      (cas_i),
    .cas_o      (cas_o),
    .cas_oe     (cas_oe),
    .addressed  (addressed),
    .vector_en  (vector_en),
    .byte_sel   (byte_sel),
    .cycle_done (cycle_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed expectation: {cas_oe, cas_o[2:0], addressed, vector_en, byte_sel[1:0], cycle_done}
  function automatic logic [8:0] pk(logic oe, logic [2:0] co, logic ad, logic ve,
                                    logic [1:0] bs, logic cd);
    return {oe, co, ad, ve, bs, cd};
  endfunction

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {cas_oe, cas_o, addressed, vector_en, byte_sel, cycle_done};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed oe/cas/addr/ven/bsel/done=%b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive inta_n, let one rising edge pass, check at next negedge.
  task automatic step(input logic v, input string tag, input logic [8:0] exp);
    inta_n = v;
    @(negedge clk);
    chk(tag, exp);
  endtask

  localparam logic [8:0] ZERO = 9'b0;

  initial begin
    rst_n  = 1'b0;
    sp_n   = 1'b1;
    sngl   = 1'b0;
    upm    = 1'b1;
    icw3   = 8'h00;
    inta_n = 1'b1;
    ack_ir = 3'd0;
    cas_i  = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset_state", ZERO);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", ZERO);

    // 1: master, slave present on IR2
    sp_n = 1'b1; icw3 = 8'h04; ack_ir = 3'd2;
    step(1'b0, "t1_ack1", pk(1, 3'd2, 0, 0, BSEL_CALL, 0));
    step(1'b1, "t1_gap1", pk(1, 3'd2, 0, 0, BSEL_CALL, 0));
    step(1'b0, "t1_ack2", pk(1, 3'd2, 0, 0, BSEL_VEC1, 0));
    step(1'b1, "t1_done", pk(0, 3'd0, 0, 0, BSEL_CALL, 1));
    step(1'b1, "t1_idle", ZERO);

    // 2: master, no slave on IR5 -> vector owned locally
    icw3 = 8'h00; ack_ir = 3'd5;
    step(1'b0, "t2_ack1", pk(0, 3'd0, 1, 0, BSEL_CALL, 0));
    step(1'b1, "t2_gap1", pk(0, 3'd0, 1, 0, BSEL_CALL, 0));
    step(1'b0, "t2_ack2", pk(0, 3'd0, 1, 1, BSEL_VEC1, 0));
    step(1'b1, "t2_done", pk(0, 3'd0, 1, 0, BSEL_CALL, 1));
    // fall in DONE starts a new cycle with freshly sampled settings
    icw3 = 8'h04; ack_ir = 3'd2;
    step(1'b0, "chain_ack1", pk(1, 3'd2, 0, 0, BSEL_CALL, 0));
    step(1'b1, "chain_gap1", pk(1, 3'd2, 0, 0, BSEL_CALL, 0));
    step(1'b0, "chain_ack2", pk(1, 3'd2, 0, 0, BSEL_VEC1, 0));
    step(1'b1, "chain_done", pk(0, 3'd0, 0, 0, BSEL_CALL, 1));
    step(1'b1, "chain_idle", ZERO);

    // 3a: slave, own ID 6, CAS carries 6
    sp_n = 1'b0; icw3 = 8'h06; cas_i = 3'd6; ack_ir = 3'd0;
    step(1'b0, "t3a_ack1", pk(0, 3'd0, 1, 0, BSEL_CALL, 0));
    cas_i = 3'd0;
    step(1'b1, "t3a_gap1", pk(0, 3'd0, 1, 0, BSEL_CALL, 0));
    step(1'b0, "t3a_ack2", pk(0, 3'd0, 1, 1, BSEL_VEC1, 0));
    step(1'b1, "t3a_done", pk(0, 3'd0, 1, 0, BSEL_CALL, 1));
    step(1'b1, "t3a_idle", ZERO);

    // 3b: slave, CAS carries 5 -> not addressed
    cas_i = 3'd5;
    step(1'b0, "t3b_ack1", ZERO);
    step(1'b1, "t3b_gap1", ZERO);
    step(1'b0, "t3b_ack2", pk(0, 3'd0, 0, 0, BSEL_VEC1, 0));
    step(1'b1, "t3b_done", pk(0, 3'd0, 0, 0, BSEL_CALL, 1));
    step(1'b1, "t3b_idle", ZERO);

    // 4: reset during GAP1 releases CAS at once
    sp_n = 1'b1; icw3 = 8'h04; ack_ir = 3'd2; cas_i = 3'd0;
    step(1'b0, "t4_ack1", pk(1, 3'd2, 0, 0, BSEL_CALL, 0));
    step(1'b1, "t4_gap1", pk(1, 3'd2, 0, 0, BSEL_CALL, 0));
    #2 rst_n = 1'b0;
    #1 chk("t4_async_reset", ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_idle_after", ZERO);
    step(1'b0, "t4_restart_ack1", pk(1, 3'd2, 0, 0, BSEL_CALL, 0));
    step(1'b1, "t4_restart_gap1", pk(1, 3'd2, 0, 0, BSEL_CALL, 0));
    step(1'b0, "t4_restart_ack2", pk(1, 3'd2, 0, 0, BSEL_VEC1, 0));
    step(1'b1, "t4_restart_done", pk(0, 3'd0, 0, 0, BSEL_CALL, 1));
    step(1'b1, "t4_restart_idle", ZERO);

    // 5: inputs change after ACK1 entry; first-edge values hold
    icw3 = 8'h04; ack_ir = 3'd2;
    step(1'b0, "t5_ack1", pk(1, 3'd2, 0, 0, BSEL_CALL, 0));
    icw3 = 8'h00; ack_ir = 3'd5; sngl = 1'b1;
    step(1'b1, "t5_gap1", pk(1, 3'd2, 0, 0, BSEL_CALL, 0));
    step(1'b0, "t5_ack2", pk(1, 3'd2, 0, 0, BSEL_VEC1, 0));
    step(1'b1, "t5_done", pk(0, 3'd0, 0, 0, BSEL_CALL, 1));
    step(1'b1, "t5_idle", ZERO);
    sngl = 1'b0;

    // 6: upm = 0, master uncascaded
    upm = 1'b0; icw3 = 8'h00; ack_ir = 3'd1;
`ifdef CASCADE_MCS80_EN
    step(1'b0, "t6_ack1", pk(0, 3'd0, 1, 1, BSEL_CALL, 0));
    step(1'b1, "t6_gap1", pk(0, 3'd0, 1, 0, BSEL_CALL, 0));
    step(1'b0, "t6_ack2", pk(0, 3'd0, 1, 1, BSEL_VEC1, 0));
    step(1'b1, "t6_gap2", pk(0, 3'd0, 1, 0, BSEL_CALL, 0));
    step(1'b0, "t6_ack3", pk(0, 3'd0, 1, 1, BSEL_VEC2, 0));
    step(1'b1, "t6_done", pk(0, 3'd0, 1, 0, BSEL_CALL, 1));
    step(1'b1, "t6_idle", ZERO);
`else
    // upm has no effect: still the two-INTA sequence
    step(1'b0, "t6_ack1", pk(0, 3'd0, 1, 0, BSEL_CALL, 0));
    step(1'b1, "t6_gap1", pk(0, 3'd0, 1, 0, BSEL_CALL, 0));
    step(1'b0, "t6_ack2", pk(0, 3'd0, 1, 1, BSEL_VEC1, 0));
    step(1'b1, "t6_done", pk(0, 3'd0, 1, 0, BSEL_CALL, 1));
    step(1'b1, "t6_idle", ZERO);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
